comp_n_bit: RTL and testbench

COMP_N_BIT -- requirements
Module: comp_n_bit

---
 rtl/comp_n_bit.sv | 111 +++++++++++
 tb/tb_comp_n_bit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/comp_n_bit.sv
// Registered N-bit magnitude comparator (unsigned or two's-complement) built
// from 8-bit lane compares merged MSB-lane first; one-cycle latency, full rate.

module comp_n_bit_lane #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         lt_o,
  output logic         eq_o
);
  assign lt_o = (a_i < b_i);
  assign eq_o = (a_i == b_i);
endmodule

module comp_n_bit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         in_valid,
  input  logic         signed_en,
  output logic         L,
  output logic         G,
  output logic         E,
  output logic         out_valid
);
  localparam int LANE_W    = 8;
  localparam int NUM_LANES = (N + LANE_W - 1) / LANE_W;
  localparam int W_PAD     = NUM_LANES * LANE_W;

  logic [N-1:0]     flip;
  logic [W_PAD-1:0] a_pad, b_pad;
  logic [NUM_LANES-1:0][LANE_W-1:0] a_lanes, b_lanes;
  logic [NUM_LANES-1:0] lane_lt, lane_eq;
  logic lt_c, eq_c, gt_c;
  logic l_q, g_q, e_q, vld_q;
  logic l_d, g_d, e_d, vld_d;

  // Inverting both sign bits maps two's complement onto unsigned order, so
  // one unsigned datapath serves both modes; zero padding sits above the MSB.
  always_comb begin
    flip        = '0;
    flip[N-1]   = signed_en;
    a_pad       = '0;
    b_pad       = '0;
    a_pad[N-1:0] = a ^ flip;
    b_pad[N-1:0] = b ^ flip;
  end

  assign a_lanes = a_pad;
  assign b_lanes = b_pad;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      comp_n_bit_lane #(.W(LANE_W)) u_lane (
        .a_i  (a_lanes[gi]),
        .b_i  (b_lanes[gi]),
        .lt_o (lane_lt[gi]),
        .eq_o (lane_eq[gi])
      );
    end
  endgenerate

  // The most significant differing lane decides the ordering.
  always_comb begin
    lt_c = 1'b0;
    eq_c = 1'b1;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      lt_c = lt_c | (eq_c & lane_lt[i]);
      eq_c = eq_c & lane_eq[i];
    end
    gt_c = ~lt_c & ~eq_c;
  end

  always_comb begin
    l_d   = l_q;
    g_d   = g_q;
    e_d   = e_q;
    vld_d = vld_q;
    if (in_valid) begin
      l_d   = lt_c;
      g_d   = gt_c;
      e_d   = eq_c;
      vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_q   <= 1'b0;
      g_q   <= 1'b0;
      e_q   <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      l_q   <= l_d;
      g_q   <= g_d;
      e_q   <= e_d;
      vld_q <= vld_d;
    end
  end

  assign L         = l_q;
  assign G         = g_q;
  assign E         = e_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_comp_n_bit.sv
// Directed and random checks for comp_n_bit at N=32.

module tb_comp_n_bit;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] a, b;
  logic         in_valid, signed_en;
  logic         L, G, E, out_valid;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  comp_n_bit #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .signed_en (signed_en),
    .L         (L),
    .G         (G),
    .E         (E),
    .out_valid (out_valid)
  );

  function automatic logic [2:0] ref_cmp(input logic [N-1:0] x, input logic [N-1:0] y, input logic s);
    if (s) return {$signed(x) < $signed(y), $signed(x) > $signed(y), x == y};
    return {x < y, x > y, x == y};
  endfunction

  // Present one sample at a falling edge; returns at the following falling edge,
  // i.e. after the capturing rising edge, with in_valid dropped again.
  task automatic drive(input logic [N-1:0] aa, input logic [N-1:0] bb, input logic s);
    @(negedge clk);
    a = aa; b = bb; signed_en = s; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    n_checks++;
    if ({L, G, E, out_valid} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_state: LGEV=%b expected 0000", {L, G, E, out_valid});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({L, G, E, out_valid} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_idle: LGEV=%b expected 0000", {L, G, E, out_valid});
    end
  endtask

  task automatic test_equality;
    drive(32'd0, 32'd0, 1'b0);
    n_checks++;
    if ({L, G, E, out_valid} !== 4'b0011) begin
      n_fail++;
      $display("FAIL equality_zero: LGEV=%b expected 0011", {L, G, E, out_valid});
    end
  endtask

  task automatic test_back_to_back;
    logic [N-1:0] va [6] = '{32'd20, 32'd220, 32'd2044, 32'd2220, 32'd2560, 32'd2230};
    logic [N-1:0] vb [6] = '{32'd30, 32'd330, 32'd430, 32'd4430, 32'd33450, 32'd47530};
    logic [3:0]   ve [6] = '{4'b1001, 4'b1001, 4'b0101, 4'b1001, 4'b1001, 4'b1001};
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_checks++;
        if ({L, G, E, out_valid} !== ve[i-1]) begin
          n_fail++;
          $display("FAIL b2b_%0d: LGEV=%b expected %b", i - 1, {L, G, E, out_valid}, ve[i-1]);
        end
      end
      if (i < 6) begin
        a = va[i]; b = vb[i]; signed_en = 1'b0; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_hold;
    drive(32'd2044, 32'd430, 1'b0);
    n_checks++;
    if ({L, G, E, out_valid} !== 4'b0101) begin
      n_fail++;
      $display("FAIL hold_setup: LGEV=%b expected 0101", {L, G, E, out_valid});
    end
    for (int i = 0; i < 3; i++) begin
      a = 32'd5 + i; b = 32'd900;
      @(negedge clk);
      n_checks++;
      if ({L, G, E, out_valid} !== 4'b0101) begin
        n_fail++;
        $display("FAIL hold_cycle_%0d: LGEV=%b expected 0101", i, {L, G, E, out_valid});
      end
    end
  endtask

  task automatic test_signed;
    logic [N-1:0] va [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    logic [N-1:0] vb [6] = '{32'h0,         32'h0,         32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    logic         vs [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [3:0]   ve [6] = '{4'b1001, 4'b0101, 4'b1001, 4'b0011, 4'b1001, 4'b0101};
    for (int i = 0; i < 6; i++) begin
      drive(va[i], vb[i], vs[i]);
      n_checks++;
      if ({L, G, E, out_valid} !== ve[i]) begin
        n_fail++;
        $display("FAIL signed_vec_%0d: LGEV=%b expected %b", i, {L, G, E, out_valid}, ve[i]);
      end
    end
  endtask

  task automatic test_async_reset;
    drive(32'd7, 32'd3, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({L, G, E, out_valid} !== 4'b0000) begin
      n_fail++;
      $display("FAIL async_reset: LGEV=%b expected 0000", {L, G, E, out_valid});
    end
    @(negedge clk);
    rst_n = 1'b1;
    a = 32'd1; b = 32'd9; in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({L, G, E, out_valid} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_release_idle: LGEV=%b expected 0000", {L, G, E, out_valid});
    end
    drive(32'd1, 32'd9, 1'b0);
    n_checks++;
    if ({L, G, E, out_valid} !== 4'b1001) begin
      n_fail++;
      $display("FAIL first_after_reset: LGEV=%b expected 1001", {L, G, E, out_valid});
    end
  endtask

  task automatic test_random;
    logic [N-1:0] ra, rb;
    logic [2:0]   exp;
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 1000; i++) begin
        ra = $urandom();
        rb = ($urandom_range(0, 7) == 0) ? ra : $urandom();
        drive(ra, rb, m[0]);
        exp = ref_cmp(ra, rb, m[0]);
        n_checks++;
        if ({L, G, E, out_valid} !== {exp, 1'b1}) begin
          n_fail++;
          $display("FAIL random_m%0d_%0d: a=%h b=%h LGEV=%b expected %b", m, i, ra, rb,
                   {L, G, E, out_valid}, {exp, 1'b1});
        end
        n_checks++;
        if ((32'(L) + 32'(G) + 32'(E)) !== 32'd1) begin
          n_fail++;
          $display("FAIL onehot_m%0d_%0d: LGE=%b expected exactly one set", m, i, {L, G, E});
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; a = '0; b = '0; in_valid = 1'b0; signed_en = 1'b0;
    test_reset;
    test_equality;
    test_back_to_back;
    test_hold;
    test_signed;
    test_async_reset;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
